// File: rtl/cv32e40p_pkg.sv
// ----------------------------------------------------------------------------
// cv32e40p_pkg
// Shared types and constants for the CNN convolution tile engine.
//   conv_tile_state_e : engine FSM states
//   TILE_WORDS        : pixels per 4x4 input tile
//   KERNEL_TAPS       : taps of a 3x3 kernel
//   TILE_OUT          : outputs of the 2x2 result tile (one MAC lane each)
//   tap_offset()      : position of kernel tap k inside the 4x4 tile,
//                       relative to the top-left pixel of an output window
//   lane_base()       : top-left pixel of the window of output lane l
// ----------------------------------------------------------------------------
package cv32e40p_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MAC,
        POST,
        EMIT,
        DONE
    } conv_tile_state_e;

    localparam int TILE_WORDS  = 16;
    localparam int KERNEL_TAPS = 9;
    localparam int TILE_OUT    = 4;

    // Tap k = ky*3+kx maps to tile offset ky*4+kx.
    function automatic logic [3:0] tap_offset(input logic [3:0] k);
        logic [3:0] off;
        case (k)
            4'd0:    off = 4'd0;
            4'd1:    off = 4'd1;
            4'd2:    off = 4'd2;
            4'd3:    off = 4'd4;
            4'd4:    off = 4'd5;
            4'd5:    off = 4'd6;
            4'd6:    off = 4'd8;
            4'd7:    off = 4'd9;
            4'd8:    off = 4'd10;
            default: off = 4'd0;
        endcase
        return off;
    endfunction

    // Lane l = oy*2+ox starts at tile offset oy*4+ox.
    function automatic logic [3:0] lane_base(input logic [1:0] l);
        return {1'b0, l[1], 1'b0, l[0]};
    endfunction

endpackage

// File: rtl/cv32e40p_conv_tile_engine_if.sv
// ----------------------------------------------------------------------------
// cv32e40p_conv_tile_engine_if
// Streaming ports of the convolution tile engine.
//   tile_valid/tile_data/tile_ready : input pixel stream (row-major, per channel)
//   res_valid/res_data/res_last/res_ready : result word stream
// Modports:
//   master : the producer/consumer side (core or testbench)
//   slave  : the engine
// ----------------------------------------------------------------------------
interface cv32e40p_conv_tile_engine_if #(
    parameter int DATA_W = 32
);
    logic              tile_valid;
    logic [DATA_W-1:0] tile_data;
    logic              tile_ready;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_last;
    logic              res_ready;

    modport master (
        output tile_valid, tile_data, res_ready,
        input  tile_ready, res_valid, res_data, res_last
    );

    modport slave (
        input  tile_valid, tile_data, res_ready,
        output tile_ready, res_valid, res_data, res_last
    );
endinterface

// File: rtl/cv32e40p_conv_mac_lane.sv
// ----------------------------------------------------------------------------
// cv32e40p_conv_mac_lane
// One output lane of the convolution engine: a signed ACC_W accumulator that
// adds the full-width product w*px each cycle en is high.
//   clk, rst : clock, synchronous active-high reset
//   clr      : clear accumulator (has priority over en)
//   en       : accumulate w*px
//   w, px    : signed weight and pixel
//   acc      : accumulator value
// ----------------------------------------------------------------------------
module cv32e40p_conv_mac_lane #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 2*DATA_W+8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] w,
    input  logic signed [DATA_W-1:0] px,
    output logic signed [ACC_W-1:0]  acc
);
    logic signed [2*DATA_W-1:0] prod;

    assign prod = w * px;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its inputs from the same clock edge regardless of block order.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
        end
    end
endmodule

// File: rtl/cv32e40p_conv_tile_engine.sv
// ----------------------------------------------------------------------------
// cv32e40p_conv_tile_engine
// Multi-channel 3x3 convolution of a 4x4 tile into a 2x2 tile, accumulated
// over up to MAX_CH input channels, with optional shift / ReLU / max-pool.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   cfg_we/addr/wdata : weight bank write (index ch*9+ky*3+kx), ignored when busy
//   start           : job start, sampled in IDLE only
//   cfg_nch/shift/relu/pool : job configuration, latched at start
//   busy            : job in progress
//   done            : one-cycle pulse after the last result is accepted
//   strm (slave)    : pixel input stream and result output stream
// Configuration macro:
//   CONV_TILE_SAT_EN : when defined, POST saturates acc>>>shift to DATA_W;
//                      otherwise the low DATA_W bits are kept.
// ----------------------------------------------------------------------------
module cv32e40p_conv_tile_engine
    import cv32e40p_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int MAX_CH = 4,
    parameter int ACC_W  = 2*DATA_W+8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_we,
    input  logic [$clog2(9*MAX_CH)-1:0]   cfg_addr,
    input  logic [DATA_W-1:0]             cfg_wdata,
    input  logic                          start,
    input  logic [$clog2(MAX_CH):0]       cfg_nch,
    input  logic [5:0]                    cfg_shift,
    input  logic                          cfg_relu,
    input  logic                          cfg_pool,
    output logic                          busy,
    output logic                          done,
    cv32e40p_conv_tile_engine_if.slave    strm
);
    localparam int NUM_W = KERNEL_TAPS*MAX_CH;
    localparam int WA_W  = $clog2(NUM_W);
    localparam int CH_W  = $clog2(MAX_CH)+1;

    conv_tile_state_e state, state_nxt;

    logic signed [DATA_W-1:0] weights  [NUM_W];
    logic signed [DATA_W-1:0] tile_buf [TILE_WORDS];
    logic signed [DATA_W-1:0] res_q    [TILE_OUT];

    logic [3:0]      pix_cnt;
    logic [3:0]      tap_cnt;
    logic [CH_W-1:0] ch_cnt;
    logic [CH_W-1:0] nch_q, nch_eff;
    logic [5:0]      shift_q;
    logic            relu_q, pool_q;
    logic [1:0]      out_idx;
    logic            last_word;

    logic [WA_W-1:0]          w_idx;
    logic signed [DATA_W-1:0] tap_w;
    logic signed [DATA_W-1:0] lane_px  [TILE_OUT];
    logic signed [ACC_W-1:0]  lane_acc [TILE_OUT];
    logic signed [ACC_W-1:0]  post_sh  [TILE_OUT];
    logic signed [DATA_W-1:0] post_r   [TILE_OUT];
    logic signed [DATA_W-1:0] pool_max;
    logic                     lane_en, lane_clr;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    // NOTE: every combinational output gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: if (strm.tile_valid && pix_cnt == 4'(TILE_WORDS-1)) state_nxt = MAC;
            MAC:  if (tap_cnt == 4'(KERNEL_TAPS-1))
                      state_nxt = ((ch_cnt + CH_W'(1)) < nch_q) ? LOAD : POST;
            POST: state_nxt = EMIT;
            EMIT: if (strm.res_ready && last_word) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    assign last_word = (out_idx == (pool_q ? 2'd0 : 2'd3));

    always_comb begin
        busy            = (state != IDLE);
        done            = (state == DONE);
        strm.tile_ready = (state == LOAD);
        strm.res_valid  = (state == EMIT);
        strm.res_last   = (state == EMIT) && last_word;
        strm.res_data   = (state == EMIT) ? res_q[out_idx] : '0;
        lane_en         = (state == MAC);
        lane_clr        = (state == DONE);
    end

    // Channel count 0 means one channel; anything above MAX_CH is clamped.
    always_comb begin
        nch_eff = cfg_nch;
        if (cfg_nch == '0)                  nch_eff = CH_W'(1);
        else if (cfg_nch > CH_W'(MAX_CH))   nch_eff = CH_W'(MAX_CH);
    end

    // ---------------- Sequencing counters and job configuration ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt <= '0;
            tap_cnt <= '0;
            ch_cnt  <= '0;
            nch_q   <= CH_W'(1);
            shift_q <= '0;
            relu_q  <= 1'b0;
            pool_q  <= 1'b0;
            out_idx <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    nch_q   <= nch_eff;
                    shift_q <= cfg_shift;
                    relu_q  <= cfg_relu;
                    pool_q  <= cfg_pool;
                    ch_cnt  <= '0;
                    pix_cnt <= '0;
                    tap_cnt <= '0;
                end
                // pix_cnt wraps to 0 after the 16th pixel, ready for the next channel.
                LOAD: if (strm.tile_valid) pix_cnt <= pix_cnt + 4'd1;
                MAC: begin
                    if (tap_cnt == 4'(KERNEL_TAPS-1)) begin
                        tap_cnt <= '0;
                        ch_cnt  <= ch_cnt + CH_W'(1);
                    end else begin
                        tap_cnt <= tap_cnt + 4'd1;
                    end
                end
                POST: out_idx <= '0;
                EMIT: if (strm.res_ready) out_idx <= out_idx + 2'd1;
                default: ;
            endcase
        end
    end

    // ---------------- Weight bank ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_W; i++) weights[i] <= '0;
        end else if (cfg_we && state == IDLE && int'(cfg_addr) < NUM_W) begin
            weights[cfg_addr] <= cfg_wdata;
        end
    end

    // ---------------- Tile buffer ----------------
    // NOTE: the tile buffer has no reset; every entry is rewritten in LOAD
    // before MAC reads it, so a reset would only add fan-out on rst.
    always_ff @(posedge clk) begin
        if (state == LOAD && strm.tile_valid) tile_buf[pix_cnt] <= strm.tile_data;
    end

    // ---------------- MAC operand select ----------------
    always_comb begin
        w_idx = WA_W'(ch_cnt) * WA_W'(KERNEL_TAPS) + WA_W'(tap_cnt);
        tap_w = weights[w_idx];
        for (int l = 0; l < TILE_OUT; l++) begin
            lane_px[l] = tile_buf[lane_base(2'(l)) + tap_offset(tap_cnt)];
        end
    end

    for (genvar l = 0; l < TILE_OUT; l++) begin : g_lane
        cv32e40p_conv_mac_lane #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk (clk),
            .rst (rst),
            .clr (lane_clr),
            .en  (lane_en),
            .w   (tap_w),
            .px  (lane_px[l]),
            .acc (lane_acc[l])
        );
    end

    // ---------------- Post-processing ----------------
`ifdef CONV_TILE_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`endif

    always_comb begin
        for (int l = 0; l < TILE_OUT; l++) begin
            post_sh[l] = lane_acc[l] >>> shift_q;
`ifdef CONV_TILE_SAT_EN
            if (post_sh[l] > SAT_MAX)      post_r[l] = SAT_MAX[DATA_W-1:0];
            else if (post_sh[l] < SAT_MIN) post_r[l] = SAT_MIN[DATA_W-1:0];
            else                           post_r[l] = post_sh[l][DATA_W-1:0];
`else
            post_r[l] = post_sh[l][DATA_W-1:0];
`endif
            if (relu_q && post_r[l][DATA_W-1]) post_r[l] = '0;
        end
        pool_max = post_r[0];
        for (int l = 1; l < TILE_OUT; l++) begin
            if (post_r[l] > pool_max) pool_max = post_r[l];
        end
    end

    // When pooling only word 0 is emitted, so it carries the maximum.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int l = 0; l < TILE_OUT; l++) res_q[l] <= '0;
        end else if (state == POST) begin
            res_q[0] <= pool_q ? pool_max : post_r[0];
            for (int l = 1; l < TILE_OUT; l++) res_q[l] <= post_r[l];
        end
    end
endmodule

// File: tb/tb_cv32e40p_conv_tile_engine.sv
`timescale 1ns/1ps
module tb_cv32e40p_conv_tile_engine;
    localparam int DATA_W = 32;
    localparam int MAX_CH = 4;
    localparam int NUM_W  = 9*MAX_CH;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [5:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        start;
    logic [2:0]  cfg_nch;
    logic [5:0]  cfg_shift;
    logic        cfg_relu;
    logic        cfg_pool;
    logic        busy;
    logic        done;

    cv32e40p_conv_tile_engine_if #(.DATA_W(DATA_W)) strm ();

    cv32e40p_conv_tile_engine #(
        .DATA_W (DATA_W),
        .MAX_CH (MAX_CH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .start     (start),
        .cfg_nch   (cfg_nch),
        .cfg_shift (cfg_shift),
        .cfg_relu  (cfg_relu),
        .cfg_pool  (cfg_pool),
        .busy      (busy),
        .done      (done),
        .strm      (strm)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t sb[$];

    logic signed [31:0] wm    [NUM_W];
    logic signed [31:0] tiles [MAX_CH][16];

    int          stall_cnt = 0;
    bit          stall_arm = 0;
    int          job_words = 0;
    bit          seen_valid = 0;
    int          first_valid_cyc = 0;
    int          start_cyc = 0;
    bit          hold_pend = 0;
    logic [31:0] hold_data;
    logic        hold_last;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Consumer readiness: normally ready, held low while stall_cnt runs.
    initial begin
        strm.res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_cnt > 0) begin
                strm.res_ready = 1'b0;
                stall_cnt--;
            end else begin
                strm.res_ready = 1'b1;
            end
        end
    end

    // Result monitor: scoreboard pop on every accepted word, stability while stalled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (hold_pend) begin
                check("stall_valid", 64'(strm.res_valid), 64'd1);
                check("stall_data",  64'(strm.res_data),  64'(hold_data));
                check("stall_last",  64'(strm.res_last),  64'(hold_last));
            end
            hold_pend = strm.res_valid && !strm.res_ready;
            hold_data = strm.res_data;
            hold_last = strm.res_last;
            if (strm.res_valid && !seen_valid) begin
                seen_valid      = 1;
                first_valid_cyc = cyc;
            end
            if (strm.res_valid && strm.res_ready) begin
                check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("res_data", 64'(strm.res_data), 64'(e.data));
                    check("res_last", 64'(strm.res_last), 64'(e.last));
                end
                job_words++;
                if (stall_arm && job_words == 2) begin
                    stall_cnt = 5;
                    stall_arm = 0;
                end
            end
        end
    end

    // Reference model: direct 3x3 convolution at 72-bit precision.
    task automatic push_expected(input int nch, input int shift, input bit relu, input bit pool);
        logic signed [71:0] acc, a, b, sh;
        logic signed [31:0] r [4];
        logic signed [31:0] mx;
        exp_t e;
        int ne, oy, ox;
        ne = (nch == 0) ? 1 : ((nch > MAX_CH) ? MAX_CH : nch);
        for (int l = 0; l < 4; l++) begin
            oy  = l / 2;
            ox  = l % 2;
            acc = '0;
            for (int c = 0; c < ne; c++)
                for (int ky = 0; ky < 3; ky++)
                    for (int kx = 0; kx < 3; kx++) begin
                        a   = wm[c*9 + ky*3 + kx];
                        b   = tiles[c][(oy+ky)*4 + ox + kx];
                        acc = acc + a*b;
                    end
            sh = acc >>> shift;
`ifdef CONV_TILE_SAT_EN
            if (sh > 72'sh7fffffff)        r[l] = 32'h7fffffff;
            else if (sh < -72'sh80000000)  r[l] = 32'h80000000;
            else                           r[l] = sh[31:0];
`else
            r[l] = sh[31:0];
`endif
            if (relu && r[l] < 0) r[l] = '0;
        end
        if (pool) begin
            mx = r[0];
            for (int l = 1; l < 4; l++) if (r[l] > mx) mx = r[l];
            e.data = mx;
            e.last = 1'b1;
            sb.push_back(e);
        end else begin
            for (int l = 0; l < 4; l++) begin
                e.data = r[l];
                e.last = (l == 3);
                sb.push_back(e);
            end
        end
    endtask

    task automatic write_w(input int addr, input logic [31:0] val);
        cfg_we    = 1'b1;
        cfg_addr  = 6'(addr);
        cfg_wdata = val;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        wm[addr] = val;
    endtask

    task automatic set_centre(input int c, input int v);
        for (int k = 0; k < 9; k++) write_w(c*9 + k, (k == 4) ? 32'(v) : 32'd0);
    endtask

    // mode 0: all ones, 1: ramp 0..15, 2: small random, 3: 0x7fffffff
    task automatic fill_tile(input int c, input int mode);
        for (int i = 0; i < 16; i++) begin
            case (mode)
                0:       tiles[c][i] = 32'sd1;
                1:       tiles[c][i] = 32'(i);
                2:       tiles[c][i] = 32'($urandom_range(0, 200)) - 32'sd100;
                default: tiles[c][i] = 32'sh7fffffff;
            endcase
        end
    endtask

    task automatic run_job(input int nch, input int shift, input bit relu, input bit pool,
                           input bit gaps, input bit disturb, input bit stall, input bit chk_lat);
        int ne, n, accepted;
        bit ok, got_done;
        ne = (nch == 0) ? 1 : ((nch > MAX_CH) ? MAX_CH : nch);
        push_expected(nch, shift, relu, pool);
        job_words  = 0;
        seen_valid = 0;
        stall_arm  = stall;
        cfg_nch    = 3'(nch);
        cfg_shift  = 6'(shift);
        cfg_relu   = relu;
        cfg_pool   = pool;
        start      = 1'b1;
        start_cyc  = cyc;
        @(posedge clk);
        #1;
        start     = 1'b0;
        // Scramble the config inputs: the job must use the latched values.
        cfg_nch   = 3'd0;
        cfg_shift = 6'd17;
        cfg_relu  = ~relu;
        cfg_pool  = ~pool;
        check("busy_after_start", 64'(busy), 64'd1);
        accepted = 0;
        for (int c = 0; c < ne; c++) begin
            for (int i = 0; i < 16; i++) begin
                if (gaps) begin
                    n = $urandom_range(0, 2);
                    repeat (n) begin
                        strm.tile_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                end
                if (disturb && c == 0 && i == 5) begin
                    start     = 1'b1;
                    cfg_we    = 1'b1;
                    cfg_addr  = 6'd4;
                    cfg_wdata = 32'd99;
                end
                strm.tile_valid = 1'b1;
                strm.tile_data  = tiles[c][i];
                ok = 0;
                n  = 0;
                while (!ok && n < 200) begin
                    @(negedge clk);
                    ok = strm.tile_ready;
                    @(posedge clk);
                    #1;
                    n++;
                end
                if (ok) accepted++;
                start  = 1'b0;
                cfg_we = 1'b0;
            end
        end
        strm.tile_valid = 1'b0;
        check("pixels_accepted", 64'(accepted), 64'(ne*16));
        got_done = 0;
        for (int k = 0; k < 300 && !got_done; k++) begin
            @(negedge clk);
            got_done = done;
            @(posedge clk);
            #1;
        end
        check("done_seen", 64'(got_done), 64'd1);
        check("done_one_cycle", 64'(done), 64'd0);
        check("idle_after_done", 64'(busy), 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);
        if (chk_lat) check("first_valid_cycle", 64'(first_valid_cyc - start_cyc), 64'd27);
        sb.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},       64'(busy),            64'd0);
        check({tag, "_tile_ready"}, 64'(strm.tile_ready), 64'd0);
        check({tag, "_res_valid"},  64'(strm.res_valid),  64'd0);
        check({tag, "_res_last"},   64'(strm.res_last),   64'd0);
        check({tag, "_done"},       64'(done),            64'd0);
        check({tag, "_res_data"},   64'(strm.res_data),   64'd0);
    endtask

    initial begin
        int spurious;
        rst             = 1'b1;
        cfg_we          = 1'b0;
        cfg_addr        = '0;
        cfg_wdata       = '0;
        start           = 1'b0;
        cfg_nch         = 3'd1;
        cfg_shift       = '0;
        cfg_relu        = 1'b0;
        cfg_pool        = 1'b0;
        strm.tile_valid = 1'b0;
        strm.tile_data  = '0;
        for (int i = 0; i < NUM_W; i++) wm[i] = '0;
        for (int c = 0; c < MAX_CH; c++) fill_tile(c, 0);
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // All weights 1, all pixels 1 -> 9 x4, with latency check.
        for (int k = 0; k < 9; k++) write_w(k, 32'd1);
        fill_tile(0, 0);
        run_job(1, 0, 0, 0, 0, 0, 0, 1);

        // Centre tap only, ramp tile -> 5,6,9,10; pooled -> 10.
        set_centre(0, 1);
        fill_tile(0, 1);
        run_job(1, 0, 0, 0, 0, 0, 0, 1);
        run_job(1, 0, 0, 1, 0, 0, 0, 0);

        // Centre -1: ReLU clamps to 0; without ReLU negative; pooled max -5.
        set_centre(0, -1);
        run_job(1, 0, 1, 0, 0, 0, 0, 0);
        run_job(1, 0, 0, 0, 0, 0, 0, 0);
        run_job(1, 0, 0, 1, 0, 0, 0, 0);

        // Two channels, centre weights 1 and 2 -> 15,18,27,30; shift 1 -> 7,9,13,15.
        set_centre(0, 1);
        set_centre(1, 2);
        fill_tile(1, 1);
        run_job(2, 0, 0, 0, 0, 0, 0, 0);
        run_job(2, 1, 0, 0, 0, 0, 0, 0);

        // Backpressure on word 2, pixel gaps, stray start and weight write.
        run_job(2, 0, 0, 0, 1, 1, 1, 0);

        // nch=0 behaves as one channel.
        run_job(0, 0, 0, 0, 0, 0, 0, 0);

        // nch above MAX_CH is clamped: random weights and tiles on all channels.
        for (int k = 0; k < NUM_W; k++) write_w(k, 32'($urandom_range(0, 40)) - 32'd20);
        for (int c = 0; c < MAX_CH; c++) fill_tile(c, 2);
        run_job(7, 0, 0, 0, 0, 0, 0, 0);
        run_job(4, 3, 1, 0, 1, 0, 0, 0);

        // Large operands: saturation when enabled, low-word wrap otherwise.
        for (int k = 0; k < 9; k++) write_w(k, 32'h7fffffff);
        fill_tile(0, 3);
        run_job(1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 9; k++) write_w(k, 32'h80000000);
        run_job(1, 0, 0, 0, 0, 0, 0, 0);
        run_job(1, 40, 0, 0, 0, 0, 0, 0);

        // Reset in the middle of MAC: immediate return to reset values, no done.
        for (int k = 0; k < 9; k++) write_w(k, 32'd1);
        cfg_nch = 3'd1;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start           = 1'b0;
        strm.tile_valid = 1'b1;
        strm.tile_data  = 32'd1;
        repeat (16) begin
            @(posedge clk);
            #1;
        end
        strm.tile_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("busy_in_mac", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("mid_rst");
        for (int i = 0; i < NUM_W; i++) wm[i] = '0;
        spurious = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || strm.res_valid) spurious++;
        end
        @(posedge clk);
        #1;
        check("no_output_after_rst", 64'(spurious), 64'd0);

        // After reset the bank holds zeros except what is rewritten; accumulators start clean.
        write_w(4, 32'd1);
        fill_tile(0, 1);
        run_job(1, 0, 0, 0, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
